uart_rx_configurable: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART receiver. Supports configurable data width, parity mode and stop-bit count. Samples at an oversampled rate with 3-sample majority voting, and reports parity, framing, overrun and break conditions. Delivers bytes through a one-deep valid/ready output register, so downstream consumers (calculator command parser, FIFOs) can stall.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_configurable.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_configurable.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver and its matching transmitter.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_ok(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic par_bit,
                                     input parity_mode_t mode);
    logic x;
    x = ^data ^ par_bit;
    case (mode)
      PARITY_ODD:  return x == 1'b1;
      PARITY_EVEN: return x == 1'b0;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one registered pulse every TICK_DIVISOR clocks, realignable via restart.
module uart_baud_tick #(
  parameter int unsigned TICK_DIVISOR = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || restart) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(TICK_DIVISOR - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_configurable.sv
// Oversampling UART receiver with configurable framing, 3-sample voting, error/break reporting
// and a one-deep valid/ready output register.
module uart_rx_configurable
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned OVERSAMPLE      = 16,
  parameter int unsigned TICK_DIVISOR    = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_detect,
  output logic                 busy
);

  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned BW       = $clog2(DATA_BITS + 1);
  localparam int unsigned MID_LO   = OVERSAMPLE / 2 - 1;
  localparam int unsigned MID      = OVERSAMPLE / 2;
  localparam int unsigned VOTE_IDX = OVERSAMPLE / 2 + 1;
  localparam parity_mode_t MODE    = parity_mode_t'(2'(PARITY));

  rx_state_t state, state_next;

  logic                 sync_1, rx_s;
  logic                 tick;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] data_sr;
  logic                 perr, ferr, par_zero;

  logic restart_c, vote_c, vote_tick_c, bit_end_c, break_cond_c;
  logic complete_c, break_c;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx;
      rx_s   <= sync_1;
    end
  end

  assign restart_c    = (state == ST_IDLE) && !rx_s;
  assign vote_c       = majority3(samp_a, samp_b, rx_s);
  assign vote_tick_c  = tick && (sample_cnt == SW'(VOTE_IDX));
  assign bit_end_c    = tick && (sample_cnt == SW'(OVERSAMPLE - 1));
  assign break_cond_c = (data_sr == '0) && par_zero && !vote_c;

  uart_baud_tick #(
    .TICK_DIVISOR(TICK_DIVISOR)
  ) u_baud_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .restart(restart_c),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete_c = 1'b0;
    break_c    = 1'b0;
    unique case (state)
      ST_IDLE: if (!rx_s) state_next = ST_START;
      ST_START: begin
        if (vote_tick_c && vote_c) state_next = ST_IDLE;
        else if (bit_end_c)        state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c && bit_cnt == BW'(DATA_BITS - 1))
          state_next = (MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end_c) state_next = ST_STOP;
      // Completion happens at the last stop vote so a following start edge is not missed.
      ST_STOP: begin
        if (vote_tick_c) begin
          if (bit_cnt == '0 && break_cond_c) begin
            state_next = ST_BREAK_WAIT;
            break_c    = 1'b1;
          end else if (bit_cnt == BW'(STOP_BITS - 1)) begin
            state_next = ST_IDLE;
            complete_c = 1'b1;
          end
        end
      end
      ST_BREAK_WAIT: if (rx_s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit timing, majority samples and frame accumulation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      data_sr    <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      par_zero   <= 1'b1;
    end else begin
      if (state == ST_IDLE || state == ST_BREAK_WAIT)
        sample_cnt <= '0;
      else if (tick)
        sample_cnt <= (sample_cnt == SW'(OVERSAMPLE - 1)) ? '0 : sample_cnt + 1'b1;

      if (tick && sample_cnt == SW'(MID_LO)) samp_a <= rx_s;
      if (tick && sample_cnt == SW'(MID))    samp_b <= rx_s;

      if (restart_c) begin
        bit_cnt  <= '0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
        par_zero <= 1'b1;
      end else if (bit_end_c && state != ST_IDLE) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
      end

      if (vote_tick_c) begin
        case (state)
          ST_DATA:   data_sr <= {vote_c, data_sr[DATA_BITS-1:1]};
          ST_PARITY: begin
            perr     <= !parity_ok(MAX_DATA_BITS'(data_sr), vote_c, MODE);
            par_zero <= !vote_c;
          end
          ST_STOP:   if (!vote_c) ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // One-deep output register; a frame completing against a stalled word is dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      break_detect  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      overrun      <= 1'b0;
      break_detect <= break_c;
      busy         <= (state_next != ST_IDLE);
      if (valid && ready) valid <= 1'b0;
      if (complete_c) begin
        if (!valid || ready) begin
          data          <= data_sr;
          parity_error  <= perr;
          framing_error <= ferr | !vote_c;
          valid         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_configurable.sv
// Directed bench for uart_rx_configurable: 8N1, 8E1 and 8N2 instances checked against a frame-level model.
module tb_uart_rx_configurable;

  localparam int unsigned CLK_HZ   = 1600000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_CLKS = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n;
  logic [2:0]      rx, ready;
  logic [2:0][7:0] data;
  logic [2:0]      valid, parity_error, framing_error, overrun, break_detect, busy;

  uart_rx_configurable #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx[0]), .data(data[0]), .valid(valid[0]),
    .ready(ready[0]), .parity_error(parity_error[0]), .framing_error(framing_error[0]),
    .overrun(overrun[0]), .break_detect(break_detect[0]), .busy(busy[0]));

  uart_rx_configurable #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                         .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8e1 (
    .clock(clock), .reset_n(reset_n), .rx(rx[1]), .data(data[1]), .valid(valid[1]),
    .ready(ready[1]), .parity_error(parity_error[1]), .framing_error(framing_error[1]),
    .overrun(overrun[1]), .break_detect(break_detect[1]), .busy(busy[1]));

  uart_rx_configurable #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS)) u_8n2 (
    .clock(clock), .reset_n(reset_n), .rx(rx[2]), .data(data[2]), .valid(valid[2]),
    .ready(ready[2]), .parity_error(parity_error[2]), .framing_error(framing_error[2]),
    .overrun(overrun[2]), .break_detect(break_detect[2]), .busy(busy[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    longint     lo;
    longint     hi;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  longint     cyc = 0;
  int         ovr_exp = 0, ovr_seen = 0, brk_exp = 0, brk_seen = 0;
  bit         held[3];
  int         vcnt[3];
  logic [7:0] last_data[3];
  logic       last_pe[3], last_fe[3];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int mode_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int stops_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every newly presented word must match the head of the expected queue.
  logic [2:0] pv = '0, pr = '0;
  logic [9:0] hd[3];
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        pv[i] = 1'b0;
        pr[i] = 1'b0;
      end else begin
        if (valid[i] && !(pv[i] && !pr[i])) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: inst %0d got data %0h, required no word", i, data[i]);
          end else begin
            e = exp_q.pop_front();
            check("word_inst", 32'(i), 32'(e.inst));
            check("word_data", 32'(data[i]), 32'(e.data));
            check("word_parity_error", 32'(parity_error[i]), 32'(e.perr));
            check("word_framing_error", 32'(framing_error[i]), 32'(e.ferr));
            check("word_latency_in_window", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
          end
          hd[i] = {parity_error[i], framing_error[i], data[i]};
          last_data[i] = data[i];
          last_pe[i]   = parity_error[i];
          last_fe[i]   = framing_error[i];
        end else if (valid[i]) begin
          check("held_word_stable", 32'({parity_error[i], framing_error[i], data[i]}), 32'(hd[i]));
        end
        if (valid[i]) vcnt[i]++;
        ovr_seen += int'(overrun[i]);
        brk_seen += int'(break_detect[i]);
        pv[i] = valid[i];
        pr[i] = ready[i];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame-level model plus line driver. par_sel < 0 sends the correct parity bit.
  task automatic send_frame(input int i, input logic [7:0] d, input int par_sel,
                            input logic stop_last, input int glitch_bit);
    logic   bits[$];
    logic   p, p_good, perr, ferr, stop_first;
    int     ones, bl, gl;
    longint t0;
    exp_t   e;
    ones = $countones(d);
    p_good = (mode_of(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    p = (par_sel < 0) ? p_good : (par_sel != 0);
    stop_first = (stops_of(i) == 2) ? 1'b1 : stop_last;
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(d[b]);
    if (mode_of(i) != 0) bits.push_back(p);
    if (stops_of(i) == 2) bits.push_back(1'b1);
    bits.push_back(stop_last);
    bl   = bits.size() - 1;
    perr = (mode_of(i) != 0) && (p != p_good);
    ferr = !stop_first || !stop_last;
    gl   = (glitch_bit < 0) ? -1 : glitch_bit + 1;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < int'(BIT_CLKS); c++) begin
        @(posedge clock);
        #1;
        rx[i] = (b == gl && c == 10) ? 1'b0 : bits[b];
        if (b == 0 && c == 0) begin
          t0 = cyc;
          if (d == 8'h00 && (mode_of(i) == 0 || !p) && !stop_first) begin
            brk_exp++;
          end else if (!ready[i] && held[i]) begin
            ovr_exp++;
          end else begin
            e.inst = i; e.data = d; e.perr = perr; e.ferr = ferr;
            e.lo = t0 + 16 * bl + 4;
            e.hi = t0 + 16 * bl + 17;
            exp_q.push_back(e);
            if (!ready[i]) held[i] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 3'b111;
    ready   = 3'b111;
    for (int i = 0; i < 3; i++) begin held[i] = 1'b0; vcnt[i] = 0; end
    idle(3);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("reset_data", 32'(data[i]), 32'd0);
      check("reset_valid", 32'(valid[i]), 32'd0);
      check("reset_busy", 32'(busy[i]), 32'd0);
      check("reset_flags", 32'({parity_error[i], framing_error[i], overrun[i], break_detect[i]}), 32'd0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(8);

    // 8N1 0xA5
    vcnt[0] = 0;
    send_frame(0, 8'hA5, -1, 1'b1, -1);
    idle(20);
    check("a5_data", 32'(last_data[0]), 32'hA5);
    check("a5_flags", 32'({last_pe[0], last_fe[0]}), 32'd0);
    check("a5_valid_cycles", 32'(vcnt[0]), 32'd1);
    check("a5_busy_after", 32'(busy[0]), 32'd0);

    // 8E1 0x03 with wrong then right parity
    send_frame(1, 8'h03, 1, 1'b1, -1);
    idle(20);
    check("e1_bad_data", 32'(last_data[1]), 32'h03);
    check("e1_bad_parity_error", 32'(last_pe[1]), 32'd1);
    send_frame(1, 8'h03, 0, 1'b1, -1);
    idle(20);
    check("e1_good_parity_error", 32'(last_pe[1]), 32'd0);

    // 8N2 framing error then back-to-back clean frame
    send_frame(2, 8'h5A, -1, 1'b0, -1);
    send_frame(2, 8'h11, -1, 1'b1, -1);
    idle(20);
    check("n2_b2b_data", 32'(last_data[2]), 32'h11);
    check("n2_b2b_framing_error", 32'(last_fe[2]), 32'd0);

    // Stalled consumer: second frame dropped
    ready[0] = 1'b0;
    send_frame(0, 8'h12, -1, 1'b1, -1);
    idle(16);
    send_frame(0, 8'h34, -1, 1'b1, -1);
    idle(16);
    check("ovr_held_data", 32'(data[0]), 32'h12);
    check("ovr_held_valid", 32'(valid[0]), 32'd1);
    check("ovr_pulses", 32'(ovr_seen), 32'd1);
    ready[0] = 1'b1;
    held[0]  = 1'b0;
    idle(4);
    send_frame(0, 8'h56, -1, 1'b1, -1);
    idle(20);
    check("ovr_after_data", 32'(last_data[0]), 32'h56);

    // Break: line held low well past a full frame
    vcnt[0] = 0;
    brk_exp++;
    rx[0] = 1'b0;
    idle(30 * BIT_CLKS);
    rx[0] = 1'b1;
    idle(32);
    check("break_pulses", 32'(brk_seen), 32'd1);
    check("break_no_valid", 32'(vcnt[0]), 32'd0);
    send_frame(0, 8'h7E, -1, 1'b1, -1);
    idle(20);
    check("break_after_data", 32'(last_data[0]), 32'h7E);

    // Glitches on idle line and inside data bit 3
    vcnt[0] = 0;
    rx[0] = 1'b0;
    idle(1);
    rx[0] = 1'b1;
    idle(3 * BIT_CLKS);
    check("idle_glitch_no_valid", 32'(vcnt[0]), 32'd0);
    check("idle_glitch_busy", 32'(busy[0]), 32'd0);
    send_frame(0, 8'hFF, -1, 1'b1, 3);
    idle(20);
    check("glitch_ff_data", 32'(last_data[0]), 32'hFF);

    // Reset in the middle of a frame
    rx[0] = 1'b0;
    idle(4 * BIT_CLKS);
    check("midframe_busy", 32'(busy[0]), 32'd1);
    reset_n = 1'b0;
    rx[0]   = 1'b1;
    idle(2);
    @(negedge clock);
    check("midreset_data", 32'(data[0]), 32'd0);
    check("midreset_valid_busy", 32'({valid[0], busy[0]}), 32'd0);
    check("midreset_flags", 32'({parity_error[0], framing_error[0], overrun[0], break_detect[0]}), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(8);
    send_frame(0, 8'h81, -1, 1'b1, -1);
    idle(20);
    check("post_reset_data", 32'(last_data[0]), 32'h81);

    idle(BIT_CLKS);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));
    check("break_total", 32'(brk_seen), 32'(brk_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
